// File: rtl/sum_accum_pkg.sv
// sum_accum_pkg: shared definitions for the sum accumulator block.
//   - default operand width and block size, so adder wrappers and benches agree
//   - output slot FSM state type and encodings (EMPTY / FULL)
//   - clog2 helper usable in parameter defaults
package sum_accum_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_COUNT = 4;

  typedef logic [0:0] state_t;
  localparam state_t EMPTY = 1'b0;
  localparam state_t FULL  = 1'b1;

  // Smallest r with 2**r >= value.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sum_accum_if.sv
// sum_accum_if: stream bundle around the sum accumulator.
//   in_valid/in_ready/in_sum/in_zero : upstream sum stream from the adder
//   flush                            : close the current partial block
//   out_valid/out_ready              : completed-block handshake
//   out_total/out_n/out_nzero        : block total, sample count, zero-sum count
// master = producer/consumer side (bench or neighbouring stages), slave = sum_accum.
interface sum_accum_if #(
  parameter int WIDTH  = sum_accum_pkg::DEF_WIDTH,
  parameter int SWIDTH = WIDTH + 1,
  parameter int COUNT  = sum_accum_pkg::DEF_COUNT,
  parameter int CWIDTH = sum_accum_pkg::clog2(COUNT) + 1,
  parameter int AWIDTH = SWIDTH + sum_accum_pkg::clog2(COUNT)
) ();

  logic              in_valid;
  logic              in_ready;
  logic [SWIDTH-1:0] in_sum;
  logic              in_zero;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [AWIDTH-1:0] out_total;
  logic [CWIDTH-1:0] out_n;
  logic [CWIDTH-1:0] out_nzero;

  modport master (
    output in_valid, in_sum, in_zero, flush, out_ready,
    input  in_ready, out_valid, out_total, out_n, out_nzero
  );

  modport slave (
    input  in_valid, in_sum, in_zero, flush, out_ready,
    output in_ready, out_valid, out_total, out_n, out_nzero
  );

endinterface

// File: rtl/sum_accum_oreg.sv
// sum_accum_oreg: single-entry output slot with valid/ready.
//   clk, rst                      : clock, synchronous active-high reset
//   load, load_total/n/nzero      : write a completed block (only when out_free)
//   out_ready                     : downstream accepts the held block
//   out_free                      : slot can take a load this cycle
//   out_valid, out_total/n/nzero  : held block
module sum_accum_oreg
  import sum_accum_pkg::*;
#(
  parameter int AWIDTH = 11,
  parameter int CWIDTH = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [AWIDTH-1:0] load_total,
  input  logic [CWIDTH-1:0] load_n,
  input  logic [CWIDTH-1:0] load_nzero,
  input  logic              out_ready,
  output logic              out_free,
  output logic              out_valid,
  output logic [AWIDTH-1:0] out_total,
  output logic [CWIDTH-1:0] out_n,
  output logic [CWIDTH-1:0] out_nzero
);

  state_t            state_p1;
  logic [AWIDTH-1:0] total_p1;
  logic [CWIDTH-1:0] n_p1;
  logic [CWIDTH-1:0] nzero_p1;

  // A draining slot counts as free, so a new block can load on the same edge
  // the old one leaves: back-to-back blocks with no bubble.
  assign out_free  = (state_p1 == EMPTY) | out_ready;
  assign out_valid = (state_p1 == FULL);
  assign out_total = total_p1;
  assign out_n     = n_p1;
  assign out_nzero = nzero_p1;

  // ---- stage p1: output slot ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1 <= EMPTY;
      total_p1 <= '0;
      n_p1     <= '0;
      nzero_p1 <= '0;
    end else if (load) begin
      state_p1 <= FULL;
      total_p1 <= load_total;
      n_p1     <= load_n;
      nzero_p1 <= load_nzero;
    end else if (out_ready) begin
      state_p1 <= EMPTY;
    end
  end

endmodule

// File: rtl/sum_accum.sv
// sum_accum: accumulates blocks of COUNT adder sums and emits one total per
// block with its sample count and zero-sum count; flush closes a partial block.
//   clk, rst : clock, synchronous active-high reset
//   bus      : sum_accum_if slave (input stream, flush, output block handshake)
module sum_accum
  import sum_accum_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int SWIDTH = WIDTH + 1,
  parameter int COUNT  = DEF_COUNT,
  parameter int CWIDTH = clog2(COUNT) + 1,
  parameter int AWIDTH = SWIDTH + clog2(COUNT)
) (
  input  logic        clk,
  input  logic        rst,
  sum_accum_if.slave  bus
);

  localparam logic [CWIDTH-1:0] LAST = CWIDTH'(COUNT - 1);

  logic [AWIDTH-1:0] acc;
  logic [AWIDTH-1:0] acc_sum;
  logic [CWIDTH-1:0] cnt;
  logic [CWIDTH-1:0] cnt_sum;
  logic [CWIDTH-1:0] zcnt;
  logic [CWIDTH-1:0] zcnt_sum;
  logic              flush_pend;
  logic              last;
  logic              accept;
  logic              out_free;
  logic              close;
  logic              do_close;

  assign last = (cnt == LAST);

  // Only the sample that would complete a block needs a free output slot;
  // every earlier sample goes straight into the accumulator.
  assign bus.in_ready = ~(last & ~out_free);
  assign accept       = bus.in_valid & bus.in_ready;

  // A flush closes only a non-empty block (counting a sample arriving now).
  assign close    = (accept & last) | ((bus.flush | flush_pend) & ((cnt != '0) | accept));
  assign do_close = close & out_free;

  // Running totals including this cycle's sample; these are what a closing
  // block loads into the output slot.
  assign acc_sum  = acc + (accept ? AWIDTH'(bus.in_sum) : '0);
  assign cnt_sum  = cnt + CWIDTH'(accept);
  assign zcnt_sum = zcnt + CWIDTH'(accept & bus.in_zero);

  // ---- stage p0: accumulator ----
  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      cnt        <= '0;
      zcnt       <= '0;
      flush_pend <= 1'b0;
    end else if (do_close) begin
      acc        <= '0;
      cnt        <= '0;
      zcnt       <= '0;
      flush_pend <= 1'b0;
    end else begin
      acc  <= acc_sum;
      cnt  <= cnt_sum;
      zcnt <= zcnt_sum;
      // Blocked close can only come from a flush; remember it until the slot frees.
      if (close) flush_pend <= 1'b1;
    end
  end

  sum_accum_oreg #(
    .AWIDTH (AWIDTH),
    .CWIDTH (CWIDTH)
  ) u_oreg (
    .clk        (clk),
    .rst        (rst),
    .load       (do_close),
    .load_total (acc_sum),
    .load_n     (cnt_sum),
    .load_nzero (zcnt_sum),
    .out_ready  (bus.out_ready),
    .out_free   (out_free),
    .out_valid  (bus.out_valid),
    .out_total  (bus.out_total),
    .out_n      (bus.out_n),
    .out_nzero  (bus.out_nzero)
  );

endmodule
